fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage directly upstream of the decode-stage control unit. Issues word-aligned fetch requests to instruction memory over a valid/ready request channel with in-order, variable-latency responses. Buffers up to two returned instructions and holds the IF/ID pipeline register that supplies `op`, `funct3` and `funct7` to decode. Handles execute-stage redirects (taken branch, JAL, JALR) by squashing younger fetches with an epoch bit.

## Interface
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `MAX_INFLIGHT`, default `2`: combined limit on outstanding requests plus buffered responses. Legal values are 1 and 2.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `imem_req_valid` output, 1 bit: fetch request valid.
- `imem_req_ready` input, 1 bit: memory accepts the request this cycle.
- `imem_req_addr` output, 32 bits: fetch address. Bits [1:0] are always 0.
- `imem_resp_valid` input, 1 bit: response data valid. Responses arrive in request order, at least 1 cycle after acceptance.
- `imem_resp_data` input, 32 bits: instruction word.
- `redirect_valid` input, 1 bit: execute resolved a taken control transfer.
- `redirect_pc` input, 32 bits: target address. Bits [1:0] are ignored (treated as 0).
- `stall` input, 1 bit: hazard unit holds IF/ID. This is the same signal that decode receives.
- `valid_D` output, 1 bit: IF/ID holds a live instruction.
- `instr_D` output, 32 bits: instruction. Reads `32'h0000_0013` (NOP) whenever `valid_D`=0.
- `pc_D` output, 32 bits: PC of `instr_D`.
- `pc_plus4_D` output, 32 bits: `pc_D + 4`, mod 2^32.
- `op_D` output, 7 bits: `instr_D[6:0]`.
- `funct3_D` output, 3 bits: `instr_D[14:12]`.
- `funct7_D` output, 7 bits: `instr_D[31:25]`.

## Operation
- **State:**
  - `fetch_pc` (32 bits).
  - `epoch` (1 bit).
  - Pending queue: `MAX_INFLIGHT` entries of {pc, epoch}, one per accepted and unanswered request.
  - Response FIFO: `MAX_INFLIGHT` entries of {pc, instr}.
  - IF/ID register.
- **Issue:**
  - `imem_req_valid` = `rst_n` & ~`redirect_valid` & (pending_count + fifo_count < `MAX_INFLIGHT`).
  - `imem_req_addr` = `fetch_pc`.
- **Accept:** when `imem_req_valid` & `imem_req_ready`:
  - push {`fetch_pc`, `epoch`} into the pending queue;
  - `fetch_pc` += 4, wrapping from `32'hFFFF_FFFC` to 0.
- **Response:** on `imem_resp_valid`, pop the pending-queue head.
  - If head.epoch ≠ `epoch`, drop the response (stale).
  - Otherwise the response is live, with pc = head.pc.
  - A response while the pending queue is empty is a protocol error: ignore it, with no state change.
- **IF/ID load:** IF/ID accepts when ~`stall` | ~`valid_D`. Source priority:
  1. FIFO head (pop);
  2. live response this cycle (bypass);
  3. none, in which case `valid_D` <= 0.

  If IF/ID does not accept, or the FIFO is non-empty, a live response is pushed into the FIFO. The FIFO never overflows, because of the credit limit.
- **Redirect:** `redirect_valid` takes priority over `stall` and accept. On the edge:
  - `fetch_pc` <= {`redirect_pc[31:2]`, 2'b00};
  - `epoch` toggles;
  - response FIFO is cleared;
  - `valid_D` <= 0.

  Pending entries are kept so that their stale responses are still matched and dropped. A response arriving in the redirect cycle is compared against the old epoch and discarded regardless.
- **Stall:** with `stall`=1 and `valid_D`=1, IF/ID holds all fields. Requests continue until credits are exhausted.
- **Reset** (`rst_n`=0 at an edge, including mid-operation):
  - `fetch_pc`=`RESET_PC`, `epoch`=0;
  - pending queue and FIFO empty;
  - `valid_D`=0, `instr_D`=NOP, `pc_D`=0, `pc_plus4_D`=4.

  `imem_req_valid`=0 in every cycle where `rst_n`=0.

## Timing
- First request: the first cycle with `rst_n`=1, at `RESET_PC`.
- Back-to-back accepts are allowed: 1 request per cycle while credits remain.
- Bypass latency: a response in cycle N is visible on `valid_D`/`instr_D` in cycle N+1 (FIFO empty, no stall).
- Throughput: with 1-cycle memory latency and `MAX_INFLIGHT`=2, sustains 1 instruction/cycle.
- Redirect penalty:
  - `redirect_valid` in cycle R → first request at the new target in cycle R+1;
  - `valid_D`=0 from R+1 until that target's response plus 1 cycle.
- Simultaneous cases:
  - Stall + live response: the response goes to the FIFO.
  - Stall release + live response with FIFO non-empty: FIFO head goes to IF/ID, the response is pushed, the count is unchanged.
  - Redirect + accept ready: no accept, because `imem_req_valid` is 0.
- All D outputs and `imem_req_addr` are registered or derived from registers only. `imem_req_valid` depends combinationally on `rst_n` and `redirect_valid`.

## Test plan
- **Reset:** reset, then release with `RESET_PC`=0 and ready=1, responses at 1-cycle latency returning `0x00500093`, `0x00A00113` → addr sequence 0, 4, 8…; `valid_D` rises 2 cycles after release with `pc_D`=0, `instr_D`=`0x00500093`, `op_D`=`7'b0010011`.
- **Stall:** stall held 4 cycles with ready=1 → at most 2 requests in flight or buffered; IF/ID frozen. On release, PCs 4 and 8 emerge on consecutive cycles with none lost or duplicated.
- **Redirect with in-flight fetches:** redirect to `0x0000_0102` while 2 requests to 0x10 and 0x14 are pending → those responses are dropped; next request address is `0x100`; `valid_D`=0 until `pc_D`=`0x100` appears.
- **Backpressure:** ready=0 for 3 cycles then 1 → `imem_req_addr` stable at the same PC throughout; accepted exactly once.
- **Wrap and reset:**
  - `fetch_pc`=`0xFFFF_FFFC` → next request address 0, and `pc_plus4_D`=0 for that instruction;
  - assert `rst_n`=0 mid-stream → next cycle `valid_D`=0, `instr_D`=`0x13`, `imem_req_valid`=0;
  - a stray response with no pending entry is ignored.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory channel: valid/ready fetch requests out, in-order data responses back.
interface fetch_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic [31:0] resp_data;

    modport master (
        output req_valid,
        output req_addr,
        input  req_ready,
        input  resp_valid,
        input  resp_data
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        output req_ready,
        output resp_valid,
        output resp_data
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: credit-limited imem requests, two-deep response buffer,
// IF/ID register for decode, and epoch-based squashing of fetches younger than a redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int          MAX_INFLIGHT = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master imem,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    input  logic         stall,
    output logic         valid_D,
    output logic [31:0]  instr_D,
    output logic [31:0]  pc_D,
    output logic [31:0]  pc_plus4_D,
    output logic [6:0]   op_D,
    output logic [2:0]   funct3_D,
    output logic [6:0]   funct7_D
);
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [2:0]  CREDITS = 3'(MAX_INFLIGHT);

    logic [31:0] fetch_pc;
    logic        epoch;

    // Pending queue: one {pc, epoch} per accepted request still awaiting its response.
    logic [31:0] pend_pc [2];
    logic        pend_ep [2];
    logic        pend_rd;
    logic        pend_wr;
    logic [1:0]  pend_cnt;

    // Response FIFO: live responses that IF/ID could not take yet.
    logic [31:0] fifo_pc    [2];
    logic [31:0] fifo_instr [2];
    logic        fifo_rd;
    logic        fifo_wr;
    logic [1:0]  fifo_cnt;

    logic        valid_q;
    logic [31:0] instr_q;
    logic [31:0] pc_q;

    logic accept;
    logic resp_pop;
    logic resp_live;
    logic ifid_load;
    logic fifo_pop;
    logic fifo_push;

    function automatic logic ptr_next(input logic p);
        return (MAX_INFLIGHT == 1) ? 1'b0 : ~p;
    endfunction

    assign imem.req_valid = rst_n & ~redirect_valid
                          & (({1'b0, pend_cnt} + {1'b0, fifo_cnt}) < CREDITS);
    assign imem.req_addr  = fetch_pc;

    assign accept    = imem.req_valid & imem.req_ready;
    assign resp_pop  = imem.resp_valid & (pend_cnt != 2'd0);
    // A response in the redirect cycle still carries the old epoch, so it is never live.
    assign resp_live = resp_pop & ~redirect_valid & (pend_ep[pend_rd] == epoch);
    assign ifid_load = ~stall | ~valid_q;
    assign fifo_pop  = ifid_load & (fifo_cnt != 2'd0);
    assign fifo_push = resp_live & (~ifid_load | (fifo_cnt != 2'd0));

    // NOTE: non-blocking assignments only in clocked blocks, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC & ~32'h3;
            epoch    <= 1'b0;
            pend_rd  <= 1'b0;
            pend_wr  <= 1'b0;
            pend_cnt <= 2'd0;
            fifo_rd  <= 1'b0;
            fifo_wr  <= 1'b0;
            fifo_cnt <= 2'd0;
            valid_q  <= 1'b0;
            instr_q  <= NOP;
            pc_q     <= 32'h0000_0000;
        end else begin
            pend_cnt <= pend_cnt + 2'(accept) - 2'(resp_pop);
            if (accept)   pend_wr <= ptr_next(pend_wr);
            if (resp_pop) pend_rd <= ptr_next(pend_rd);

            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ~32'h3;
                epoch    <= ~epoch;
                fifo_rd  <= 1'b0;
                fifo_wr  <= 1'b0;
                fifo_cnt <= 2'd0;
                valid_q  <= 1'b0;
            end else begin
                if (accept) fetch_pc <= fetch_pc + 32'd4;
                fifo_cnt <= fifo_cnt + 2'(fifo_push) - 2'(fifo_pop);
                if (fifo_push) fifo_wr <= ptr_next(fifo_wr);
                if (fifo_pop)  fifo_rd <= ptr_next(fifo_rd);
                if (ifid_load) begin
                    valid_q <= fifo_pop | resp_live;
                    if (fifo_pop) begin
                        pc_q    <= fifo_pc[fifo_rd];
                        instr_q <= fifo_instr[fifo_rd];
                    end else if (resp_live) begin
                        pc_q    <= pend_pc[pend_rd];
                        instr_q <= imem.resp_data;
                    end
                end
            end
        end
    end

    // NOTE: queue storage is not reset; the occupancy counts alone decide which entries are meaningful.
    always_ff @(posedge clk) begin
        if (accept) begin
            pend_pc[pend_wr] <= fetch_pc;
            pend_ep[pend_wr] <= epoch;
        end
        if (fifo_push) begin
            fifo_pc[fifo_wr]    <= pend_pc[pend_rd];
            fifo_instr[fifo_wr] <= imem.resp_data;
        end
    end

    assign valid_D    = valid_q;
    assign instr_D    = valid_q ? instr_q : NOP;
    assign pc_D       = pc_q;
    assign pc_plus4_D = pc_q + 32'd4;
    assign op_D       = instr_D[6:0];
    assign funct3_D   = instr_D[14:12];
    assign funct7_D   = instr_D[31:25];
endmodule
